mux_scan_ctrl: RTL and testbench

//  Upstream sequencer for the 4:1 select mux (mux_4x1_case).
//  - Drives the mux select `s` round-robin over the enabled channels.
//  - Holds each channel for a programmable dwell time.
//  - Samples the mux output on the last dwell cycle of each channel.
//  - Assembles one bit per channel into a 4-bit frame, offered downstream on a valid/ready handshake.

---
 rtl/mux_scan_ctrl_pkg.sv | 6 +
 rtl/mux_next_ch.sv | 23 ++
 rtl/mux_scan_ctrl.sv | 98 +++++++++
 tb/tb_mux_scan_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// mux_scan_ctrl_pkg: shared channel count, select width and FSM state encoding for the mux scanner
package mux_scan_ctrl_pkg;
  localparam int NCH = 4;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/mux_next_ch.sv
// mux_next_ch: lowest enabled channel, next enabled channel above cur, and last-channel flag
module mux_next_ch
  import mux_scan_ctrl_pkg::*;
(
  input  logic [SEL_W-1:0] cur,
  input  logic [NCH-1:0]   mask,
  output logic [SEL_W-1:0] first,
  output logic [SEL_W-1:0] next,
  output logic             is_last
);
  always_comb begin
    first = '0;
    next = '0;
    is_last = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) first = SEL_W'(i);
      if (mask[i] && i > int'(cur)) begin
        next = SEL_W'(i);
        is_last = 1'b0;
      end
    end
  end
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin mux select scanner assembling one sampled bit per channel into a handshaked frame
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NCH-1:0]     ch_mask,
  output logic [SEL_W-1:0]   s,
  input  logic               mux_out,
  output logic [NCH-1:0]     frame_data,
  output logic [NCH-1:0]     frame_mask,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               busy
);
  state_t state, state_n;
  logic [SEL_W-1:0] s_n, first, nxt;
  logic [DWELL_W-1:0] cnt, cnt_n, dwell_q, dwell_n;
  logic [NCH-1:0] cap, cap_n, fd_n, fm_n;
  logic fv_n, is_last, start;
  // during a scan the walk follows the latched mask; otherwise the live mask feeds the first-channel lookup
  mux_next_ch u_next (
    .cur(s),
    .mask(state == SCAN ? frame_mask : ch_mask),
    .first(first),
    .next(nxt),
    .is_last(is_last)
  );
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    s_n = s;
    cnt_n = cnt;
    dwell_n = dwell_q;
    cap_n = cap;
    fd_n = frame_data;
    fm_n = frame_mask;
    fv_n = frame_valid;
    start = en && |ch_mask && (state == IDLE || (state == HOLD && frame_ready));
    case (state)
      SCAN: begin
        if (!en) state_n = IDLE;
        else if (cnt != '0) cnt_n = cnt - DWELL_W'(1);
        else begin
          cap_n[s] = mux_out;
          if (is_last) begin
            fd_n = cap_n;
            fv_n = 1'b1;
            state_n = HOLD;
          end else begin
            s_n = nxt;
            cnt_n = dwell_q;
          end
        end
      end
      HOLD: begin
        if (frame_ready) begin
          fv_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (start) begin
      state_n = SCAN;
      s_n = first;
      cnt_n = dwell;
      dwell_n = dwell;
      fm_n = ch_mask;
      cap_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s <= '0;
      cnt <= '0;
      dwell_q <= '0;
      cap <= '0;
      frame_data <= '0;
      frame_mask <= '0;
      frame_valid <= 1'b0;
    end else begin
      state <= state_n;
      s <= s_n;
      cnt <= cnt_n;
      dwell_q <= dwell_n;
      cap <= cap_n;
      frame_data <= fd_n;
      frame_mask <= fm_n;
      frame_valid <= fv_n;
    end
  end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed scenarios for the mux scanner driving a behavioural 4:1 mux
module tb_mux_scan_ctrl;
  logic clk = 1'b0;
  logic rst, en, frame_ready, mux_out, frame_valid, busy;
  logic [7:0] dwell;
  logic [3:0] ch_mask, in_v, frame_data, frame_mask;
  logic [1:0] s;
  logic [11:0] obs, exp_v;
  logic [3:0] top3, exp3;
  int errors = 0;
  int checks = 0;

  mux_scan_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .dwell(dwell), .ch_mask(ch_mask), .s(s),
    .mux_out(mux_out), .frame_data(frame_data), .frame_mask(frame_mask),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  assign mux_out = in_v[s];
  assign obs = {busy, frame_valid, s, frame_data, frame_mask};
  assign top3 = {busy, frame_valid, s};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; frame_ready = 1'b0; ch_mask = 4'h0; dwell = 8'd0; in_v = 4'h0;
    tick(); tick();
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", obs, 12'h000); end
    rst = 1'b0;
  endtask

  task automatic test_zero_mask;
    en = 1'b1; ch_mask = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 12'h000) begin errors++; $display("FAIL zero_mask_idle cyc=%0d got=%h exp=%h", i, obs, 12'h000); end
    end
    ch_mask = 4'b1000; dwell = 8'd0; in_v = 4'b1000; frame_ready = 1'b1;
    tick();
    exp_v = {1'b1, 1'b0, 2'd3, 4'h0, 4'h8};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL single_start got=%h exp=%h", obs, exp_v); end
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_v = {1'b1, 1'b1, 2'd3, 4'h8, 4'h8};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL single_frame k=%0d got=%h exp=%h", k, obs, exp_v); end
      tick();
      exp_v = {1'b1, 1'b0, 2'd3, 4'h8, 4'h8};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL single_restart k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    in_v = 4'h0;
    tick();
    exp_v = {1'b1, 1'b1, 2'd3, 4'h0, 4'h8};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL single_zero_bit got=%h exp=%h", obs, exp_v); end
    en = 1'b0;
    tick();
    exp_v = {1'b0, 1'b0, 2'd3, 4'h0, 4'h8};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL single_stop got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_full_scan;
    ch_mask = 4'hF; dwell = 8'd0; in_v = 4'b1010; frame_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp3 = {1'b1, 1'b0, 2'(i)};
      checks++;
      if (top3 !== exp3) begin errors++; $display("FAIL full_scan_sel edge=%0d got=%h exp=%h", i + 1, top3, exp3); end
    end
    tick();
    exp_v = {1'b1, 1'b1, 2'd3, 4'b1010, 4'hF};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL full_scan_frame got=%h exp=%h", obs, exp_v); end
    en = 1'b0;
    tick();
    checks++;
    if (top3[3:2] !== 2'b00) begin errors++; $display("FAIL full_scan_accept got=%b exp=00", top3[3:2]); end
  endtask

  task automatic test_dwell;
    ch_mask = 4'b0101; dwell = 8'd2; in_v = 4'b0001; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp3 = {1'b1, 1'b0, (i < 3) ? 2'd0 : 2'd2};
      checks++;
      if (top3 !== exp3) begin errors++; $display("FAIL dwell_sel edge=%0d got=%h exp=%h", i + 1, top3, exp3); end
    end
    tick();
    exp_v = {1'b1, 1'b1, 2'd2, 4'b0001, 4'b0101};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL dwell_frame got=%h exp=%h", obs, exp_v); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    ch_mask = 4'hF; dwell = 8'd0; in_v = 4'b0110; frame_ready = 1'b0; en = 1'b1;
    repeat (5) tick();
    exp_v = {1'b1, 1'b1, 2'd3, 4'b0110, 4'hF};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL bp_frame got=%h exp=%h", obs, exp_v); end
    in_v = 4'hF; ch_mask = 4'b0011; dwell = 8'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    ch_mask = 4'hF; dwell = 8'd0; in_v = 4'b1001; frame_ready = 1'b1;
    tick();
    exp3 = {1'b1, 1'b0, 2'd0};
    checks++;
    if (top3 !== exp3) begin errors++; $display("FAIL bp_accept_restart got=%h exp=%h", top3, exp3); end
    repeat (4) tick();
    exp_v = {1'b1, 1'b1, 2'd3, 4'b1001, 4'hF};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL bp_next_frame got=%h exp=%h", obs, exp_v); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_en_drop;
    ch_mask = 4'hF; dwell = 8'd1; in_v = 4'h0; en = 1'b1;
    repeat (5) tick();
    exp3 = {1'b1, 1'b0, 2'd2};
    checks++;
    if (top3 !== exp3) begin errors++; $display("FAIL drop_at_ch2 got=%h exp=%h", top3, exp3); end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp3 = {1'b0, 1'b0, 2'd2};
      checks++;
      if (top3 !== exp3) begin errors++; $display("FAIL drop_idle cyc=%0d got=%h exp=%h", i, top3, exp3); end
    end
    in_v = 4'hF; en = 1'b1;
    tick();
    exp3 = {1'b1, 1'b0, 2'd0};
    checks++;
    if (top3 !== exp3) begin errors++; $display("FAIL drop_restart got=%h exp=%h", top3, exp3); end
    ch_mask = 4'b0001; dwell = 8'd5;
    repeat (7) tick();
    exp3 = {1'b1, 1'b0, 2'd3};
    checks++;
    if (top3 !== exp3) begin errors++; $display("FAIL drop_midframe_ignore got=%h exp=%h", top3, exp3); end
    tick();
    exp_v = {1'b1, 1'b1, 2'd3, 4'hF, 4'hF};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL drop_clean_frame got=%h exp=%h", obs, exp_v); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_max_dwell;
    ch_mask = 4'b0001; dwell = 8'd255; in_v = 4'b0001; en = 1'b1; frame_ready = 1'b1;
    tick();
    repeat (255) tick();
    exp3 = {1'b1, 1'b0, 2'd0};
    checks++;
    if (top3 !== exp3) begin errors++; $display("FAIL maxdwell_early got=%h exp=%h", top3, exp3); end
    tick();
    exp_v = {1'b1, 1'b1, 2'd0, 4'b0001, 4'b0001};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL maxdwell_frame got=%h exp=%h", obs, exp_v); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    ch_mask = 4'hF; dwell = 8'd0; in_v = 4'b0011; frame_ready = 1'b0; en = 1'b1;
    repeat (5) tick();
    checks++;
    if (frame_valid !== 1'b1) begin errors++; $display("FAIL rstmid_hold_valid got=%b exp=1", frame_valid); end
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL rst_in_hold got=%h exp=%h", obs, 12'h000); end
    rst = 1'b0;
    tick(); tick();
    exp3 = {1'b1, 1'b0, 2'd1};
    checks++;
    if (top3 !== exp3) begin errors++; $display("FAIL rstmid_scan got=%h exp=%h", top3, exp3); end
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL rst_in_scan got=%h exp=%h", obs, 12'h000); end
    rst = 1'b0; in_v = 4'b0101; frame_ready = 1'b1;
    repeat (5) tick();
    exp_v = {1'b1, 1'b1, 2'd3, 4'b0101, 4'hF};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_clean_restart got=%h exp=%h", obs, exp_v); end
    en = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_final_idle got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_zero_mask();
    test_full_scan();
    test_dwell();
    test_back_to_back();
    test_en_drop();
    test_max_dwell();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
